fifo_wrarb2: RTL
================

# fifo_wrarb2

Two-requester, packet-granular round-robin write arbiter feeding the shared 15-entry, 36-bit SRL FIFO. Each requester presents 36-bit beats with a `last` marker. The arbiter grants one requester for a whole packet, registers the selected beat, and drives the FIFO write port. It throttles on the FIFO's `rfd` so the one-cycle registered write can never overflow the store. It also truncates runaway packets at a programmable beat limit.

## Interface
Parameters:
- `MAXBEATS`, 64: maximum beats per grant, range 2..255; reaching it forces grant release.

Ports:
- `clk`  in  1  master clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `d0`, `d1`  in  36 each  requester 0 and requester 1 beat data
- `iv0`, `iv1`  in  1 each  requester beat valid
- `last0`, `last1`  in  1 each  final beat of packet, qualified by `iv`
- `rdy0`, `rdy1`  out  1 each  beat accepted this cycle when `ivN & rdyN`
- `pdo`  out  36  registered beat to FIFO data input
- `ov`  out  1  registered FIFO write strobe, connects to FIFO `iv`
- `src`  out  1  requester index of the beat on `pdo`
- `rfd`  in  1  FIFO ready-for-data, low at 14 or 15 entries
- `gnt`  out  2  one-hot current grant, 00 when idle
- `err`  out  1  sticky; set on forced truncation at `MAXBEATS`

## Operation
- **States:** `IDLE`, `GNT0`, `GNT1`.
- **`IDLE`:** no beats accepted.
  - If exactly one `ivN` is high, go to `GNTN`.
  - If both are high, go to `GNT(pri)`, where `pri` is the favoured requester.
  - If neither is high, stay in `IDLE`.
- **Ready:** `rdyN = (state==GNTN) & rfd`, combinational.
- **Accept:** `accN = ivN & rdyN`. On accept:
  - `pdo <= dN`, `src <= N`, `ov <= 1`.
  - Otherwise `ov <= 0`, and `pdo`/`src` hold.
- **Beat count:** `cnt` is 8 bits. It clears on entry to a grant state and increments on each accept.
- **Grant release.** An accept with `lastN=1`, or an accept where `cnt==MAXBEATS-1`, does all of the following:
  - state goes to `IDLE`;
  - `pri <= ~N`;
  - `cnt <= 0`.
- **Truncation:** if release is caused by the `MAXBEATS` limit and `lastN=0`, set `err`. The remaining beats of that requester are treated as a new packet at its next grant.
- **Inter-packet bubble:** there is always one `IDLE` cycle between packets.
- **Stall:** a granted requester with `ivN=0` holds the grant indefinitely. There is no timeout other than the beat limit.
- **Backpressure:** `rfd=0` drops `rdy`. Grant, `cnt` and `pri` hold.
- **`err`:** cleared only by reset.
- **Reset values:** state `IDLE`, `pri=0`, `cnt=0`, `pdo=0`, `src=0`, `ov=0`, `err=0`. Consequently `gnt=00` and `rdy0=rdy1=0`.

## Timing
- Arbitration latency: `ivN` high in `IDLE` at cycle t gives `rdyN` at t+1, provided `rfd=1`.
- Write latency: a beat accepted at cycle t appears as `pdo`/`ov` at t+1 and is written into the FIFO at the t+1 edge.
- Throughput: 1 beat/clk while granted and `rfd=1`.
- Overflow safety: accepting at 13 entries can place two writes in flight, bringing the FIFO to 15 entries. `rfd` drops at 14 entries, so no third write is accepted. Never use FIFO `full` for throttling.
- Simultaneous `last` and `rfd` fall: the accepted beat completes and release proceeds normally.
- Reset mid-packet: outputs return to their reset values immediately and asynchronously. Any in-flight `ov` is lost. Flushing the FIFO is the system's responsibility.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `{IDLE, GNT0, GNT1}`;
  - `DW=36`;
  - `CW=8` (beat counter width).
- Single flat module. No sub-module is needed; the 2-way round-robin pick is three lines inline.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream → all outputs are zero within the same cycle; after release, `gnt=00`.
- **Single packet:** req0 sends 3 beats `0x1`, `0x2`, `0x3` with `last` on the third, `rfd=1` → `ov` high for 3 cycles starting one cycle after the first `rdy0`, `pdo` sequence 1,2,3, `src=0`, then `gnt=00`.
- **Contention:** `iv0` and `iv1` both held continuously, 2-beat packets → grants alternate 0,1,0,1 starting with 0, with one idle cycle between packets.
- **Backpressure:** `rfd=0` for 4 cycles mid-packet → `rdy` is low for those cycles, no `ov`, no lost or duplicated beats, grant holds.
- **Truncation:** `MAXBEATS=4`, req1 streams 6 beats with no `last` → release after beat 4, `err=1`, `pri` moves to 0, and the remaining beats arrive after the next grant to 1.
- **Overflow guard:** model a FIFO at 13 entries with continuous valid beats → exactly 2 further writes occur and the FIFO never exceeds 15 entries.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// fifo_arb_pkg
// Shared types and widths for the two-requester FIFO write arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

   localparam int DW = 36;
   localparam int CW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

endpackage : fifo_arb_pkg

`default_nettype wire

// File: rtl/fifo_wrarb2.sv
// ============================================================================
// fifo_wrarb2
// Packet-granular two-way round-robin write arbiter with registered FIFO write
// port, rfd throttling and beat-limit truncation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wrarb2
   import fifo_arb_pkg::*;
#(
   parameter int MAXBEATS = 64
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] d0,
   input  logic [DW-1:0] d1,
   input  logic          iv0,
   input  logic          iv1,
   input  logic          last0,
   input  logic          last1,
   output logic          rdy0,
   output logic          rdy1,
   output logic [DW-1:0] pdo,
   output logic          ov,
   output logic          src,
   input  logic          rfd,
   output logic [1:0]    gnt,
   output logic          err
);

   localparam logic [CW-1:0] C_CNT_LAST = CW'(MAXBEATS - 1);

   arb_state_e    state_q, state_d;
   logic          pri_q, pri_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] pdo_q, pdo_d;
   logic          src_q, src_d;
   logic          ov_q, ov_d;
   logic          err_q, err_d;

   logic          w_sel;
   logic          w_acc;
   logic          w_last;
   logic          w_limit;
   logic          w_release;
   logic [DW-1:0] w_data;

   assign rdy0      = (state_q == GNT0) & rfd;
   assign rdy1      = (state_q == GNT1) & rfd;
   assign w_sel     = (state_q == GNT1);
   assign w_acc     = (iv0 & rdy0) | (iv1 & rdy1);
   assign w_last    = w_sel ? last1 : last0;
   assign w_data    = w_sel ? d1 : d0;
   assign w_limit   = (cnt_q == C_CNT_LAST);
   assign w_release = w_acc & (w_last | w_limit);

   always_comb begin
      state_d = state_q;
      pri_d   = pri_q;
      cnt_d   = cnt_q;
      pdo_d   = pdo_q;
      src_d   = src_q;
      ov_d    = w_acc;
      err_d   = err_q;

      if (w_acc) begin
         pdo_d = w_data;
         src_d = w_sel;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Favoured requester only matters when both are waiting
            if (iv0 & iv1)  state_d = pri_q ? GNT1 : GNT0;
            else if (iv0)   state_d = GNT0;
            else if (iv1)   state_d = GNT1;
         end
         GNT0, GNT1: begin
            if (w_release) begin
               state_d = IDLE;
               pri_d   = ~w_sel;
               cnt_d   = '0;
               err_d   = err_q | (w_limit & ~w_last);
            end else if (w_acc) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pri_q   <= 1'b0;
         cnt_q   <= '0;
         pdo_q   <= '0;
         src_q   <= 1'b0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pri_q   <= pri_d;
         cnt_q   <= cnt_d;
         pdo_q   <= pdo_d;
         src_q   <= src_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   end

   assign pdo = pdo_q;
   assign ov  = ov_q;
   assign src = src_q;
   assign err = err_q;
   assign gnt = {state_q == GNT1, state_q == GNT0};

endmodule : fifo_wrarb2

`default_nettype wire
